// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The full result is computed at launch and committed to HI/LO after a fixed busy period.
module mul_div_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MulOp,
  input  logic [1:0]  MTHILO,
  input  logic [1:0]  MFHILO,
  input  logic        Flush,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] Out
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             divz_q, divz_d;

  logic             is_div, is_signed;
  logic [63:0]      prod;
  logic [31:0]      b_safe;
  logic signed [31:0] a_s, b_s, quo_s, rem_s;
  logic [31:0]      quo_u, rem_u;
  logic [31:0]      res_hi, res_lo;

  // Encodings 1xx all mean "no operation"
  assign is_div    = MulOp[1];
  assign is_signed = MulOp[0];
  assign Start     = ~MulOp[2] & ~busy_q & ~Flush;
  assign Busy      = busy_q;

  // Result datapath; divisor forced to 1 on zero so the unused result stays defined
  always_comb begin
    b_safe = (B == 32'd0) ? 32'd1 : B;
    a_s    = A;
    b_s    = b_safe;
    quo_s  = a_s / b_s;
    rem_s  = a_s % b_s;
    quo_u  = A / b_safe;
    rem_u  = A % b_safe;
    if (is_signed) begin
      prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    end else begin
      prod = {32'd0, A} * {32'd0, B};
    end
    if (is_div) begin
      res_hi = is_signed ? 32'(rem_s) : rem_u;
      res_lo = is_signed ? 32'(quo_s) : quo_u;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  // Next-state: launch, busy countdown with commit, or move-to HI/LO
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    divz_d   = divz_q;
    if (Start) begin
      tmp_hi_d = res_hi;
      tmp_lo_d = res_lo;
      cnt_d    = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
      busy_d   = 1'b1;
      divz_d   = is_div & (B == 32'd0);
    end else if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (!divz_q) begin
          hi_d = tmp_hi_q;
          lo_d = tmp_lo_q;
        end
      end
    end else if (!Flush) begin
      if (MTHILO == 2'b01) begin
        hi_d = A;
      end else if (MTHILO == 2'b00) begin
        lo_d = A;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      divz_q   <= divz_d;
    end
  end

  // Move-from read port: committed registers only, no bypass
  always_comb begin
    case (MFHILO)
      2'b10:   Out = hi_q;
      2'b01:   Out = lo_q;
      default: Out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, hand sequences for
// flush/reset/divide-by-zero corners, and randomized ops against an arithmetic model.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] A, B, Out;
  logic [2:0]  MulOp;
  logic [1:0]  MTHILO, MFHILO;
  logic        Flush, Start, Busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mhi, mlo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs [6];

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MulOp(MulOp), .MTHILO(MTHILO),
    .MFHILO(MFHILO), .Flush(Flush), .Start(Start), .Busy(Busy), .Out(Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    MulOp = 3'b100; MTHILO = 2'b10; MFHILO = 2'b00; Flush = 1'b0;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    MFHILO = 2'b10; #1 check({tag, "_hi"}, Out, eh);
    MFHILO = 2'b01; #1 check({tag, "_lo"}, Out, el);
    MFHILO = 2'b00; #1 check({tag, "_none"}, Out, 32'd0);
  endtask

  // Launch one op, count busy cycles, then read back HI/LO
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int n, input bit fl_busy, input logic [1:0] mt);
    logic [31:0] old_hi;
    int cnt;
    old_hi = mhi;
    @(negedge clk);
    MulOp = op; A = a; B = b; MTHILO = mt; Flush = 1'b0;
    #1 check({tag, "_start"}, {31'd0, Start}, 32'd1);
    @(posedge clk); #1;
    MulOp = 3'b100; MTHILO = 2'b10;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 1) begin
        MFHILO = 2'b10;
        #1 check({tag, "_nobypass"}, Out, old_hi);
        MFHILO = 2'b00;
        Flush = fl_busy;
      end
      if (cnt == 2) begin
        MulOp = 3'b001;
        #1 check({tag, "_start_busy"}, {31'd0, Start}, 32'd0);
        MulOp = 3'b100;
      end
      @(posedge clk); #1;
    end
    Flush = 1'b0;
    check({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
    mhi = ehi; mlo = elo;
    read_hilo(tag, ehi, elo);
  endtask

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'b000: begin p = longint'(a) * longint'(b); hi = 32'(p >> 32); lo = 32'(p); end
      3'b001: begin q = sa * sb; hi = 32'(q >>> 32); lo = 32'(q); end
      3'b010: if (b != 0) begin lo = a / b; hi = a % b; end
      3'b011: if (b != 0) begin q = sa / sb; r = sa % sb; lo = 32'(q); hi = 32'(r); end
      default: ;
    endcase
  endtask

  initial begin
    logic [31:0] eh, el, ra, rb;
    int sel;

    vecs[0] = '{3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2] = '{3'b011, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'b010, 32'd7,        32'd2,        32'd1,        32'd3,        10};
    vecs[4] = '{3'b011, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[5] = '{3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};

    idle(); A = 32'd0; B = 32'd0;
    reset = 1'b1;
    mhi = 32'd0; mlo = 32'd0;
    repeat (2) @(posedge clk);
    #1 check("rst_busy", {31'd0, Busy}, 32'd0);
    read_hilo("rst", 32'd0, 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].cyc, 1'b0, 2'b10);

    // mthi then read back next cycle
    @(negedge clk); MTHILO = 2'b01; A = 32'h1234;
    @(posedge clk); #1 idle();
    mhi = 32'h1234;
    read_hilo("mthi", mhi, mlo);

    // divu by zero: timing unchanged, registers kept
    run_op("divu0", 3'b010, 32'd99, 32'd0, mhi, mlo, 10, 1'b0, 2'b10);

    // Flush blocks a launch
    @(negedge clk); MulOp = 3'b001; A = 32'd5; B = 32'd5; Flush = 1'b1;
    #1 check("flush_start", {31'd0, Start}, 32'd0);
    @(posedge clk); #1 check("flush_busy", {31'd0, Busy}, 32'd0);
    idle();
    read_hilo("flush_op", mhi, mlo);

    // Flush blocks an MT
    @(negedge clk); MTHILO = 2'b00; A = 32'hDEADBEEF; Flush = 1'b1;
    @(posedge clk); #1 idle();
    read_hilo("flush_mt", mhi, mlo);

    // Reserved op encoding does not launch
    @(negedge clk); MulOp = 3'b101; A = 32'd3; B = 32'd3;
    #1 check("op101_start", {31'd0, Start}, 32'd0);
    @(posedge clk); #1 check("op101_busy", {31'd0, Busy}, 32'd0);
    idle();

    // Launch wins over a simultaneous MT
    run_op("mt_vs_op", 3'b000, 32'd5, 32'd6, 32'd0, 32'd30, 5, 1'b0, 2'b01);

    // Flush during busy does not abort
    run_op("flush_busy_op", 3'b010, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b1, 2'b10);

    // Randomized ops and MTs against the model
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 5);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      if (sel < 4) begin
        eh = mhi; el = mlo;
        model(3'(sel), ra, rb, eh, el);
        run_op($sformatf("rnd%0d", i), 3'(sel), ra, rb, eh, el,
               (sel >= 2) ? 10 : 5, 1'($urandom_range(0, 1)), 2'b10);
      end else begin
        @(negedge clk);
        MTHILO = 2'($urandom_range(0, 1)); A = ra; Flush = (sel == 5);
        if (!Flush) begin
          if (MTHILO == 2'b01) mhi = ra; else mlo = ra;
        end
        @(posedge clk); #1 idle();
        read_hilo($sformatf("rnd_mt%0d", i), mhi, mlo);
      end
    end

    // Ensure nonzero HI/LO before the reset test
    run_op("pre_rst", 3'b001, 32'd11, 32'd13, 32'd0, 32'd143, 5, 1'b0, 2'b10);
    @(negedge clk); MulOp = 3'b011; A = 32'hFFFFFFF9; B = 32'd2;
    @(posedge clk); #1 MulOp = 3'b100;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 check("midrst_busy", {31'd0, Busy}, 32'd0);
    mhi = 32'd0; mlo = 32'd0;
    read_hilo("midrst", 32'd0, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("post_rst_busy", {31'd0, Busy}, 32'd0);
    read_hilo("post_rst", 32'd0, 32'd0);
    run_op("after_rst", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b0, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
